// File: rtl/dtw_result_arbiter.sv
// Round-robin arbiter funnelling per-core DTW results into one stream FIFO, with flush
// padding to packet boundaries. Define DTW_ARB_TAG_EN to tag issued words with the core index.
module dtw_result_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int PKT_WORDS = 8,
    parameter logic [C_M_AXIS_TDATA_WIDTH-1:0] PAD_WORD = 32'hFFFF_FFFF
) (
    input  logic                                      ACLK,
    input  logic                                      ARESET,
    input  logic [NUM_CORES-1:0]                      core_req,
    input  logic [NUM_CORES*C_M_AXIS_TDATA_WIDTH-1:0] core_data,
    output logic [NUM_CORES-1:0]                      core_ack,
    input  logic                                      flush,
    output logic                                      flush_done,
    output logic                                      dtw_fifo_wren,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]           dtw_fifo_din,
    input  logic                                      dtw_fifo_full,
    output logic [$clog2(PKT_WORDS)-1:0]              pkt_pos,
    output logic                                      busy
);
    localparam int W     = C_M_AXIS_TDATA_WIDTH;
    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int POS_W = $clog2(PKT_WORDS);

    typedef enum logic [1:0] {ARB, ISSUE, PAD} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] last_grant_reg, last_grant_next;
    logic [IDX_W-1:0] grant_reg, grant_next;
    logic [POS_W-1:0] pkt_pos_reg, pkt_pos_next;
    logic             flush_pending_reg, flush_pending_next;
    logic             flush_done_reg, flush_done_next;
    logic [W-1:0]     word_reg, word_next;

    logic [W-1:0]     core_word [NUM_CORES];
    logic [IDX_W-1:0] rr_idx;
    logic             rr_found;
    int               rr_cand;
    logic             flush_req;
    logic             write_ok;
    logic             pad_wrap;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slice
            assign core_word[gi] = core_data[gi*W +: W];
        end
    endgenerate

    // Scan from the farthest candidate back to last_grant+1 so the nearest requester wins.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        rr_cand  = 0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            rr_cand = (int'(last_grant_reg) + k) % NUM_CORES;
            if (core_req[rr_cand[IDX_W-1:0]]) begin
                rr_idx   = rr_cand[IDX_W-1:0];
                rr_found = 1'b1;
            end
        end
    end

    // A flush pulse seen in the same cycle acts immediately; repeats merge into one pending flush.
    assign flush_req = flush_pending_reg | flush;
    assign write_ok  = (state_reg != ARB) && !dtw_fifo_full && !ARESET;
    assign pad_wrap  = (state_reg == PAD) && write_ok && (pkt_pos_reg == POS_W'(PKT_WORDS-1));

    always_comb begin
        state_next         = state_reg;
        last_grant_next    = last_grant_reg;
        grant_next         = grant_reg;
        word_next          = word_reg;
        pkt_pos_next       = pkt_pos_reg;
        flush_pending_next = flush_req;
        flush_done_next    = 1'b0;
        core_ack           = '0;
        case (state_reg)
            ARB: begin
                if (flush_req) begin
                    if (pkt_pos_reg != '0) begin
                        state_next = PAD;
                    end else begin
                        flush_done_next    = 1'b1;
                        flush_pending_next = 1'b0;
                    end
                end else if (rr_found) begin
                    grant_next = rr_idx;
                    word_next  = core_word[rr_idx];
`ifdef DTW_ARB_TAG_EN
                    word_next[W-1 -: IDX_W] = rr_idx;
`endif
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (write_ok) begin
                    core_ack[grant_reg] = 1'b1;
                    last_grant_next     = grant_reg;
                    pkt_pos_next        = pkt_pos_reg + 1'b1;
                    state_next          = ARB;
                end
            end
            PAD: begin
                if (write_ok) begin
                    pkt_pos_next = pkt_pos_reg + 1'b1;
                    if (pad_wrap) begin
                        flush_pending_next = 1'b0;
                        state_next         = ARB;
                    end
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg         <= ARB;
            last_grant_reg    <= IDX_W'(NUM_CORES-1);
            grant_reg         <= '0;
            word_reg          <= '0;
            pkt_pos_reg       <= '0;
            flush_pending_reg <= 1'b0;
            flush_done_reg    <= 1'b0;
        end else begin
            state_reg         <= state_next;
            last_grant_reg    <= last_grant_next;
            grant_reg         <= grant_next;
            word_reg          <= word_next;
            pkt_pos_reg       <= pkt_pos_next;
            flush_pending_reg <= flush_pending_next;
            flush_done_reg    <= flush_done_next;
        end
    end

    assign dtw_fifo_wren = write_ok;
    assign dtw_fifo_din  = (state_reg == PAD) ? PAD_WORD : word_reg;
    assign flush_done    = flush_done_reg | pad_wrap;
    assign pkt_pos       = pkt_pos_reg;
    assign busy          = (state_reg != ARB);

endmodule

// File: tb/tb_dtw_result_arbiter.sv
// Self-checking bench for dtw_result_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_dtw_result_arbiter;
    localparam int NC = 4;
    localparam int PK = 8;
    localparam logic [31:0] PAD = 32'hFFFF_FFFF;
`ifdef DTW_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] core_data;
    logic [3:0]   ack;
    logic         flush;
    logic         flush_done;
    logic         wren;
    logic [31:0]  din;
    logic         full;
    logic [2:0]   pos;
    logic         busy;

    always #5 clk = ~clk;

    dtw_result_arbiter dut (
        .ACLK(clk), .ARESET(rst), .core_req(req), .core_data(core_data), .core_ack(ack),
        .flush(flush), .flush_done(flush_done), .dtw_fifo_wren(wren), .dtw_fifo_din(din),
        .dtw_fifo_full(full), .pkt_pos(pos), .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [31:0] din_log[$];
    logic [3:0]  ack_log[$];
    int          wr_cyc[$];

    // Reference model: what the arbiter owes the FIFO, in transaction terms.
    int          m_count;   // words written since reset
    int          m_last;    // last core served
    bit          m_have;    // a captured result awaits writing
    int          m_grant;
    logic [31:0] m_word;
    int          m_pads;    // filler words still owed to finish a flush
    bit          m_pend;
    bit          m_done_next;
    bit          auto_drop = 1'b0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= NC; k++)
            if (r[(last + k) % NC]) return (last + k) % NC;
        return -1;
    endfunction

    function automatic logic [31:0] tag_word(input logic [31:0] w, input int idx);
        logic [1:0] t;
        t = idx[1:0];
        return TAG_EN ? {t, w[29:0]} : w;
    endfunction

    task automatic model_reset();
        m_count = 0; m_last = NC - 1; m_have = 0; m_grant = 0; m_word = '0;
        m_pads = 0; m_pend = 0; m_done_next = 0;
    endtask

    task automatic step();
        logic [3:0]  e_ack;
        logic [31:0] e_din;
        logic        e_wren, e_done, e_busy, fl;
        int          drop_idx;
        drop_idx = -1;
        @(negedge clk);
        cyc++;
        if (wren) begin
            din_log.push_back(din);
            ack_log.push_back(ack);
            wr_cyc.push_back(cyc);
            $display("cyc=%0d write din=%h ack=%b pkt_pos=%0d", cyc, din, ack, pos);
        end
        if (flush_done) done_cnt++;
        if (rst) begin
            chk("rst_cycle_wren", {63'd0, wren}, 64'd0);
            chk("rst_cycle_ack", {60'd0, ack}, 64'd0);
            model_reset();
        end else begin
            e_wren = 1'b0; e_ack = '0; e_din = '0;
            e_done = m_done_next;
            e_busy = (m_pads > 0) || m_have;
            if (m_pads > 0) begin
                e_wren = !full; e_din = PAD;
                if (!full && m_pads == 1) e_done = 1'b1;
            end else if (m_have) begin
                e_wren = !full; e_din = m_word;
                if (!full) e_ack = 4'(1 << m_grant);
            end
            chk("wren", {63'd0, wren}, {63'd0, e_wren});
            chk("ack", {60'd0, ack}, {60'd0, e_ack});
            chk("flush_done", {63'd0, flush_done}, {63'd0, e_done});
            chk("busy", {63'd0, busy}, {63'd0, e_busy});
            chk("pkt_pos", {61'd0, pos}, 64'(m_count % PK));
            if (e_wren) chk("din", {32'd0, din}, {32'd0, e_din});
            // advance the model across the coming edge
            m_done_next = 0;
            fl = m_pend || flush;
            if (m_pads > 0) begin
                if (!full) begin m_count++; m_pads--; end
                m_pend = (m_pads == 0) ? 1'b0 : fl;
            end else if (m_have) begin
                if (!full) begin
                    m_count++; m_last = m_grant; m_have = 0;
                    if (auto_drop) drop_idx = m_grant;
                end
                m_pend = fl;
            end else if (fl) begin
                if (m_count % PK != 0) begin
                    m_pads = PK - (m_count % PK); m_pend = 1;
                end else begin
                    m_done_next = 1; m_pend = 0;
                end
            end else if (req != 0) begin
                m_grant = rr_pick(req, m_last);
                m_word  = tag_word(core_data[m_grant*32 +: 32], m_grant);
                m_have  = 1;
            end
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (drop_idx >= 0) req[drop_idx] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; flush = 1'b0; full = 1'b0;
        step();
        rst = 1'b0;
        din_log.delete(); ack_log.delete(); wr_cyc.delete();
        done_cnt = 0;
    endtask

    initial begin
        int c0;
        int nlog;
        rst = 1'b1; req = '0; flush = 1'b0; full = 1'b0; core_data = '0;
        model_reset();
        @(posedge clk); #1;
        do_reset();
        step();
        chk("reset_din", {32'd0, din}, 64'd0);
        chk("reset_pos", {61'd0, pos}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);

        // alternating two held requesters
        core_data[0*32 +: 32] = 32'h11;
        core_data[2*32 +: 32] = 32'h33;
        auto_drop = 1'b0;
        c0 = cyc;
        req = 4'b0101;
        repeat (8) step();
        req = '0;
        chk("alt_count", 64'(din_log.size()), 64'd4);
        chk("alt_latency", 64'(wr_cyc[0]), 64'(c0 + 2));
        chk("alt_rate", 64'(wr_cyc[1] - wr_cyc[0]), 64'd2);
        chk("alt_din0", {32'd0, din_log[0]}, {32'd0, tag_word(32'h11, 0)});
        chk("alt_din1", {32'd0, din_log[1]}, {32'd0, tag_word(32'h33, 2)});
        chk("alt_ack0", {60'd0, ack_log[0]}, 64'b0001);
        chk("alt_ack1", {60'd0, ack_log[1]}, 64'b0100);
        chk("alt_ack2", {60'd0, ack_log[2]}, 64'b0001);

        // all four requesting: strict rotation, packet wraps after 8 writes
        do_reset();
        for (int i = 0; i < NC; i++) core_data[i*32 +: 32] = 32'h100 + 32'(i);
        req = 4'b1111;
        repeat (16) step();
        req = '0;
        chk("rot_count", 64'(ack_log.size()), 64'd8);
        for (int i = 0; i < 8; i++) chk("rot_ack", {60'd0, ack_log[i]}, 64'(1 << (i % 4)));
        chk("rot_pos_wrap", {61'd0, pos}, 64'd0);

        // stall on full; core drops request after grant and is still served
        do_reset();
        auto_drop = 1'b1;
        core_data[2*32 +: 32] = 32'hABCD_0002;
        req = 4'b0100;
        step();
        req = '0;
        full = 1'b1;
        repeat (5) begin
            step();
            chk("stall_din", {32'd0, din}, {32'd0, tag_word(32'hABCD_0002, 2)});
        end
        full = 1'b0;
        step();
        step();
        chk("stall_writes", 64'(din_log.size()), 64'd1);
        chk("stall_ack", {60'd0, ack_log[0]}, 64'b0100);

        // flush mid-packet pads to the boundary, then the waiting core is served
        do_reset();
        core_data[0*32 +: 32] = 32'h0000_0C0C;
        repeat (3) begin req[0] = 1'b1; step(); step(); end
        req = 4'b0001;
        flush = 1'b1;
        repeat (8) step();
        chk("flush_count", 64'(din_log.size()), 64'd9);
        for (int i = 3; i < 8; i++) chk("flush_pad", {32'd0, din_log[i]}, {32'd0, PAD});
        chk("flush_then_core0", {32'd0, din_log[8]}, {32'd0, tag_word(32'h0000_0C0C, 0)});
        chk("flush_done_once", 64'(done_cnt), 64'd1);

        // flush on an empty packet: done next cycle, nothing written
        do_reset();
        flush = 1'b1;
        step();
        step();
        chk("empty_flush_done", 64'(done_cnt), 64'd1);
        chk("empty_flush_writes", 64'(din_log.size()), 64'd0);

        // core 3 tagging
        do_reset();
        core_data[3*32 +: 32] = 32'h0000_00AB;
        req = 4'b1000;
        step(); step();
        chk("tag_din", {32'd0, din_log[0]}, TAG_EN ? 64'hC000_00AB : 64'h0000_00AB);

        // reset in the middle of padding
        do_reset();
        core_data[1*32 +: 32] = 32'h55;
        repeat (5) begin req[1] = 1'b1; step(); step(); end
        full = 1'b1;
        flush = 1'b1;
        step();
        step();
        chk("pad_pos5", {61'd0, pos}, 64'd5);
        chk("pad_busy", {63'd0, busy}, 64'd1);
        nlog = din_log.size();
        rst = 1'b1;
        step();
        rst = 1'b0;
        full = 1'b0;
        repeat (6) step();
        chk("abort_writes", 64'(din_log.size()), 64'(nlog));
        chk("abort_pos", {61'd0, pos}, 64'd0);
        chk("abort_done", 64'(done_cnt), 64'd0);

        // randomized traffic against the model
        do_reset();
        auto_drop = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NC; i++) begin
                if (!req[i] && $urandom_range(3) == 0) begin
                    core_data[i*32 +: 32] = $urandom;
                    req[i] = 1'b1;
                end
            end
            full  = ($urandom_range(9) < 3);
            flush = ($urandom_range(39) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dtw_result_arbiter.md
DTW_RESULT_ARBITER -- requirements
Module: dtw_result_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CORES, default 4: number of DTW cores sharing the result FIFO (2..16).
REQ-002 The block SHALL have parameter C_M_AXIS_TDATA_WIDTH, default 32: result word width.
REQ-003 The block SHALL have parameter PKT_WORDS, default 8: words per output stream packet (power of two).
REQ-004 The block SHALL have parameter PAD_WORD, default 32'hFFFF_FFFF: filler word written during flush.
REQ-005 The block SHALL have ports, clock and reset first:
- ACLK  in  1  sole clock; all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- core_req  in  NUM_CORES  per-core result-valid request
- core_data  in  NUM_CORES*C_M_AXIS_TDATA_WIDTH  per-core result, core i at bits [i*W +: W]
- core_ack  out  NUM_CORES  one-hot, one-cycle pulse; result consumed
- flush  in  1  single-cycle pulse; pad current packet to PKT_WORDS boundary
- flush_done  out  1  one-cycle pulse; flush complete
- dtw_fifo_wren  out  1  write strobe to the result stream FIFO
- dtw_fifo_din  out  C_M_AXIS_TDATA_WIDTH  write data
- dtw_fifo_full  in  1  FIFO cannot accept a write
- pkt_pos  out  clog2(PKT_WORDS)  index of the next word within the current packet
- busy  out  1  high in any state other than ARB

Function
REQ-006 The FSM SHALL have exactly three states: ARB, ISSUE, PAD.
REQ-007 In ARB, when flush_pending=1, the FSM SHALL enter PAD if pkt_pos!=0; otherwise it SHALL pulse flush_done on the next cycle, clear flush_pending and stay in ARB. Flush SHALL take priority over requests.
REQ-008 In ARB, with no pending flush and core_req!=0, the block SHALL grant the first requesting core searching upward, with wrap, from last_grant+1. It SHALL capture that core's core_data and index into registers and enter ISSUE.
REQ-009 In ISSUE, dtw_fifo_wren SHALL equal !dtw_fifo_full. dtw_fifo_din SHALL be the captured word, held stable while full.
REQ-010 In the cycle dtw_fifo_wren=1 in ISSUE, the block SHALL:
- pulse core_ack for the granted core;
- set last_grant to that index;
- increment pkt_pos modulo PKT_WORDS;
- return to ARB.
REQ-011 Minimum latency SHALL be: core_req sampled in ARB at cycle N, dtw_fifo_wren and core_ack at N+1. Sustained rate SHALL be one word per 2 cycles.
REQ-012 In PAD, dtw_fifo_wren SHALL equal !dtw_fifo_full with dtw_fifo_din=PAD_WORD, and pkt_pos SHALL increment per write. On the write that wraps pkt_pos to 0, the block SHALL pulse flush_done, clear flush_pending and return to ARB.
REQ-013 A flush pulse in any state SHALL set flush_pending. A flush arriving while flush_pending=1 SHALL be merged into it, not queued.
REQ-014 A core that drops core_req after grant SHALL still have its captured word written and SHALL still receive core_ack. Cores SHALL hold core_req until core_ack.
REQ-015 dtw_fifo_wren SHALL never assert while dtw_fifo_full=1. core_ack SHALL never have more than one bit set.
REQ-016 pkt_pos wrap PKT_WORDS-1 -> 0 SHALL align with the downstream TLAST word.

Reset
REQ-017 With ARESET=1 at a rising edge, the block SHALL set:
- state=ARB, last_grant=NUM_CORES-1 (first grant goes to core 0), pkt_pos=0, flush_pending=0;
- core_ack=0, flush_done=0, dtw_fifo_wren=0, dtw_fifo_din=0, busy=0.
REQ-018 Reset asserted mid-ISSUE or mid-PAD SHALL abort without writing, and the captured word SHALL be discarded.

Configuration
REQ-019 With macro DTW_ARB_TAG_EN defined, ISSUE writes SHALL replace the top clog2(NUM_CORES) bits of the captured word with the granted core index. PAD_WORD SHALL be written unmodified.
REQ-020 Without DTW_ARB_TAG_EN, ISSUE writes SHALL carry core_data bits unmodified.

Verification
REQ-021 Reset, then core_req=4'b0101 held with data 0x11/0x33, full=0 -> writes 0x11 (ack 0001), then 0x33 (ack 0100), alternating, one write per 2 cycles.
REQ-022 core_req=4'b1111 for 8 grants -> ack order 0,1,2,3,0,1,2,3; pkt_pos returns to 0 after the 8th write.
REQ-023 Grant core 2, hold dtw_fifo_full=1 for 5 cycles -> wren=0 and din stable for 5 cycles; single write and ack on the cycle full drops.
REQ-024 Three words written, then flush with core_req=4'b0001 -> five PAD_WORD writes, flush_done, then core 0 served; flush at pkt_pos=0 -> flush_done next cycle, no writes.
REQ-025 With DTW_ARB_TAG_EN, core 3 data 0x0000_00AB -> din 0xC000_00AB. Without the macro -> 0x0000_00AB.
REQ-026 ARESET pulsed during PAD at pkt_pos=5 -> no further writes; pkt_pos=0, flush_done never pulses.
